reg_file_mp: RTL
================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, 32, register width in bits.
REQ-002 Parameter DEPTH, 32, number of registers; power of two, >=2.
REQ-003 Parameter NRD, 2, number of read ports, >=1.
REQ-004 Parameter ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes.
REQ-005 Derived constant ADDR_W = clog2(DEPTH).
REQ-006 CLK  input  1  single clock; all state updates on rising edge.
REQ-007 RST_N  input  1  reset, asynchronous, active-low.
REQ-008 AR  input  NRD*ADDR_W  packed read addresses; port k uses slice k.
REQ-009 DR  output  NRD*DATA_W  packed read data; port k uses slice k.
REQ-010 PEND_R  output  NRD  pending flag of the register addressed by each read port.
REQ-011 AW  input  ADDR_W  write address.
REQ-012 DIN  input  DATA_W  write data.
REQ-013 REG_WRITE  input  1  write enable.
REQ-014 ISSUE  input  1  mark register AI as pending (awaiting a producer).
REQ-015 AI  input  ADDR_W  pending-mark address.
REQ-016 CLR_REQ  input  1  request a full-bank clear.
REQ-017 BUSY  output  1  high while a clear sequence runs.
REQ-018 CLR_DONE  output  1  one-cycle pulse when a clear sequence completes.

Function
REQ-019 Write: at rising CLK, if REG_WRITE=1, BUSY=0 and not (ZERO_REG=1 and AW=0), register AW takes DIN.
REQ-020 Read: combinational, zero latency; DR slice k = register AR[k].
REQ-021 Bypass: if a write per REQ-019 is qualified this cycle and AW=AR[k], DR slice k = DIN (write-first).
REQ-022 ZERO_REG=1: read of address 0 returns 0 and PEND_R reports 0, regardless of bypass or stored state.
REQ-023 Scoreboard: one pending bit per register; ISSUE=1 with BUSY=0 sets bit AI at rising CLK.
REQ-024 A qualified write clears pending bit AW at rising CLK.
REQ-025 Same-cycle ISSUE and qualified write to the same address: set wins, bit ends 1.
REQ-026 PEND_R[k] is combinational from stored bits; no bypass of same-cycle set/clear.
REQ-027 Clear FSM states: IDLE, CLEAR; counter CNT of ADDR_W bits.
REQ-028 IDLE -> CLEAR when CLR_REQ=1; CNT loads 0.
REQ-029 In CLEAR, each cycle register CNT and pending bit CNT are written 0, CNT increments.
REQ-030 CLEAR -> IDLE on the cycle register DEPTH-1 is cleared; CLR_DONE=1 that following cycle only.
REQ-031 Clear takes exactly DEPTH cycles; BUSY=1 for all of them, BUSY=0 in the cycle CLR_DONE=1.
REQ-032 While BUSY=1, REG_WRITE, ISSUE and CLR_REQ are ignored; no bypass applies.
REQ-033 While BUSY=1, reads return current stored contents (cleared or not yet cleared).
REQ-034 CLR_REQ held high in IDLE after completion starts a new clear on the next cycle.

Reset
REQ-035 RST_N=0 asynchronously: all pending bits 0, CNT=0, FSM=CLEAR, BUSY=1, CLR_DONE=0.
REQ-036 After RST_N deasserts, the bank clears in DEPTH cycles per REQ-029..REQ-030; no register array reset.
REQ-037 Reset mid-clear restarts the clear from register 0.

Structure
REQ-038 Shared package holds the FSM state enumeration and the default parameter constants.
REQ-039 One sub-module, reg_file_sb, implements the pending-bit scoreboard; storage and FSM stay in the top.
REQ-040 Storage is an array of DEPTH x DATA_W flops/distributed RAM, no reset on data.

Verification
REQ-041 Reset release, DEPTH=32: BUSY=1 for 32 cycles, CLR_DONE pulse at cycle 32, all reads 0.
REQ-042 Write AW=5 DIN=0xDEADBEEF with AR[0]=5 same cycle -> DR0=0xDEADBEEF combinationally and after edge.
REQ-043 Write AW=0 DIN=0x1234, ZERO_REG=1 -> DR of address 0 remains 0.
REQ-044 ISSUE AI=7, next cycle PEND_R=1 at AR=7; write AW=7 -> cleared; simultaneous ISSUE+write AW=7 -> stays 1.
REQ-045 CLR_REQ with reg 3=0xA5 and pend 3=1; REG_WRITE during BUSY ignored; after CLR_DONE reg 3=0, pend 3=0.
REQ-046 RST_N pulsed low at clear cycle 10 -> BUSY stays 1, clear restarts, CLR_DONE 32 cycles after release.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// reg_file_mp_pkg: shared types and default parameters for the multi-port register file.
//   ST_IDLE  - bank available for reads, writes and pending marks
//   ST_CLEAR - bank being zeroed one register per cycle
package reg_file_mp_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_DEPTH    = 32;
   localparam int DEF_NRD      = 2;
   localparam int DEF_ZERO_REG = 1;

endpackage

// File: rtl/reg_file_sb.sv
// reg_file_sb: pending-bit scoreboard, one bit per register.
//   i_clk, i_rst_n      clock, asynchronous active-low reset (all bits cleared)
//   i_set, i_set_addr   mark a register pending (wins over any same-cycle clear)
//   i_clr, i_clr_addr   producer write retires a pending register
//   i_wipe, i_wipe_addr bank-clear sequencer zeroes one bit per cycle
//   i_ar                packed read addresses, one slice per read port
//   o_pend_r            stored pending bit per read port (no same-cycle bypass)
module reg_file_sb
   import reg_file_mp_pkg::*;
#(
   parameter int DEPTH    = DEF_DEPTH,
   parameter int NRD      = DEF_NRD,
   parameter int ZERO_REG = DEF_ZERO_REG,
   localparam int ADDR_W  = $clog2(DEPTH)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_set,
   input  logic [ADDR_W-1:0]     i_set_addr,
   input  logic                  i_clr,
   input  logic [ADDR_W-1:0]     i_clr_addr,
   input  logic                  i_wipe,
   input  logic [ADDR_W-1:0]     i_wipe_addr,
   input  logic [NRD*ADDR_W-1:0] i_ar,
   output logic [NRD-1:0]        o_pend_r
);

   logic [DEPTH-1:0] r_pend;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_pend <= '0;
      else
         for (int i = 0; i < DEPTH; i++)
            if (i_set && i_set_addr == ADDR_W'(i)) r_pend[i] <= 1'b1;
            else if ((i_clr && i_clr_addr == ADDR_W'(i)) || (i_wipe && i_wipe_addr == ADDR_W'(i)))
               r_pend[i] <= 1'b0;
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_a;
      assign w_a         = i_ar[k*ADDR_W +: ADDR_W];
      // register 0 never reports pending when it is hardwired to zero
      assign o_pend_r[k] = (ZERO_REG != 0 && w_a == '0) ? 1'b0 : r_pend[w_a];
   end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file with write-first bypass, pending scoreboard and bank clear.
//   i_clk, i_rst_n  clock, asynchronous active-low reset (starts a bank clear)
//   i_ar, o_dr      packed read addresses / combinational read data, one slice per port
//   o_pend_r        pending flag of the register addressed by each read port
//   i_aw, i_din     write address / data, enabled by i_reg_write
//   i_issue, i_ai   mark register i_ai pending
//   i_clr_req       request a full-bank clear
//   o_busy          high while the clear sequence runs
//   o_clr_done      one-cycle pulse after the last register is cleared
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int NRD      = DEF_NRD,
   parameter int ZERO_REG = DEF_ZERO_REG,
   localparam int ADDR_W  = $clog2(DEPTH)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [NRD*ADDR_W-1:0] i_ar,
   output logic [NRD*DATA_W-1:0] o_dr,
   output logic [NRD-1:0]        o_pend_r,
   input  logic [ADDR_W-1:0]     i_aw,
   input  logic [DATA_W-1:0]     i_din,
   input  logic                  i_reg_write,
   input  logic                  i_issue,
   input  logic [ADDR_W-1:0]     i_ai,
   input  logic                  i_clr_req,
   output logic                  o_busy,
   output logic                  o_clr_done
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] w_cnt_nxt;
   logic              r_clr_done;
   logic              w_last;
   logic              w_busy;
   logic              w_wr_q;
   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_CLEAR;
         r_cnt      <= '0;
         r_clr_done <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_clr_done <= w_last;
      end
   end

   // the counter wraps to 0 after the last register, so leaving CLEAR needs no extra reload
   always_comb begin
      w_last      = r_state == ST_CLEAR && r_cnt == ADDR_W'(DEPTH - 1);
      w_state_nxt = r_state == ST_IDLE ? (i_clr_req ? ST_CLEAR : ST_IDLE) : (w_last ? ST_IDLE : ST_CLEAR);
      w_cnt_nxt   = r_state == ST_CLEAR ? r_cnt + 1'b1 : '0;
   end

   always_comb begin
      w_busy     = r_state == ST_CLEAR;
      o_busy     = w_busy;
      o_clr_done = r_clr_done;
   end

   assign w_wr_q = i_reg_write && !w_busy && !(ZERO_REG != 0 && i_aw == '0);

   // data storage carries no reset; the clear sequence zeroes it instead
   always_ff @(posedge i_clk) begin
      if (w_busy) r_mem[r_cnt] <= '0;
      else if (w_wr_q) r_mem[i_aw] <= i_din;
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_a;
      assign w_a = i_ar[k*ADDR_W +: ADDR_W];
      // write-first bypass; w_wr_q is already low while clearing
      assign o_dr[k*DATA_W +: DATA_W] = (ZERO_REG != 0 && w_a == '0) ? '0 :
                                        (w_wr_q && i_aw == w_a) ? i_din : r_mem[w_a];
   end

   reg_file_sb #(
      .DEPTH    (DEPTH),
      .NRD      (NRD),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_set       (i_issue && !w_busy),
      .i_set_addr  (i_ai),
      .i_clr       (w_wr_q),
      .i_clr_addr  (i_aw),
      .i_wipe      (w_busy),
      .i_wipe_addr (r_cnt),
      .i_ar        (i_ar),
      .o_pend_r    (o_pend_r)
   );

endmodule
